// File: rtl/mux_sel_gen_if.sv
// Bus between the Versat controller and the select-sequence generator:
// start/advance controls, configuration words, and the select/done results.
interface mux_sel_gen_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              running;
  logic              run;
  logic [CNT_W-1:0]  delay0;
  logic [CNT_W-1:0]  hold0;
  logic [CNT_W-1:0]  hold1;
  logic [CNT_W-1:0]  hold2;
  logic [CNT_W-1:0]  hold3;
  logic [CNT_W-1:0]  iter;
  logic [DATA_W-1:0] out0;
  logic              done;

  modport master (
    output running, run, delay0, hold0, hold1, hold2, hold3, iter,
    input  out0, done
  );

  modport slave (
    input  running, run, delay0, hold0, hold1, hold2, hold3, iter,
    output out0, done
  );
endinterface

// File: rtl/mux_sel_gen.sv
// Select-sequence generator for the 4-way registered selector: emits select 0..3, each held
// for a programmed number of cycles, over a programmed number of passes.
// Optional feature macro: MUX_SEL_GEN_PINGPONG_EN (odd passes walk the slots in descending order).
module mux_sel_gen #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  mux_sel_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    GEN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  dcnt_r, dcnt_s;
  logic [CNT_W-1:0]  hcnt_r, hcnt_s;
  logic [CNT_W-1:0]  pass_r, pass_s;
  logic [CNT_W-1:0]  iter_r;
  logic [CNT_W-1:0]  hold_r [4];
  logic [1:0]        slot_r, slot_s;
  logic [DATA_W-1:0] out_r, out_s;
  logic              done_r, done_s;

  logic [3:0]        mask_s;
  logic [3:0]        mask_in_s;
  logic [2:0]        run_first_s;
  logic [2:0]        nxt_s;
  logic [2:0]        first_s;
  logic [CNT_W-1:0]  pass_inc_s;
  logic              empty_s;
  logic              last_cyc_s;

  // Lowest enabled slot at or above lo; bit 2 flags that one was found.
  function automatic logic [2:0] scan_up(input logic [3:0] mask, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      r = (mask[i] && (3'(i) >= lo)) ? {1'b1, 2'(i)} : r;
    end
    return r;
  endfunction

`ifdef MUX_SEL_GEN_PINGPONG_EN
  // Highest enabled slot strictly below hi; bit 2 flags that one was found.
  function automatic logic [2:0] scan_down(input logic [3:0] mask, input logic [2:0] hi);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i <= 3; i++) begin
      r = (mask[i] && (3'(i) < hi)) ? {1'b1, 2'(i)} : r;
    end
    return r;
  endfunction
`endif

  assign mask_in_s   = {bus.hold3 != {CNT_W{1'b0}}, bus.hold2 != {CNT_W{1'b0}},
                        bus.hold1 != {CNT_W{1'b0}}, bus.hold0 != {CNT_W{1'b0}}};
  assign mask_s      = {hold_r[3] != {CNT_W{1'b0}}, hold_r[2] != {CNT_W{1'b0}},
                        hold_r[1] != {CNT_W{1'b0}}, hold_r[0] != {CNT_W{1'b0}}};
  assign run_first_s = scan_up(mask_in_s, 3'd0);
  assign empty_s     = (iter_r == {CNT_W{1'b0}}) || (mask_s == 4'b0000);
  assign pass_inc_s  = pass_r + CNT_W'(1);
  // The current slot always has a non-zero hold while generating, so hold-1 cannot wrap.
  assign last_cyc_s  = (hcnt_r == (hold_r[slot_r] - CNT_W'(1)));

`ifdef MUX_SEL_GEN_PINGPONG_EN
  assign nxt_s   = pass_r[0] ? scan_down(mask_s, {1'b0, slot_r})
                             : scan_up(mask_s, {1'b0, slot_r} + 3'd1);
  assign first_s = pass_inc_s[0] ? scan_down(mask_s, 3'd4) : scan_up(mask_s, 3'd0);
`else
  assign nxt_s   = scan_up(mask_s, {1'b0, slot_r} + 3'd1);
  assign first_s = scan_up(mask_s, 3'd0);
`endif

  // Next-state and next-output logic; run overrides everything, running=0 is a pure stall.
  always_comb begin
    state_s = state_r;
    dcnt_s  = dcnt_r;
    hcnt_s  = hcnt_r;
    pass_s  = pass_r;
    slot_s  = slot_r;
    out_s   = out_r;
    done_s  = done_r;
    if (bus.run) begin
      dcnt_s  = bus.delay0;
      hcnt_s  = {CNT_W{1'b0}};
      pass_s  = {CNT_W{1'b0}};
      slot_s  = run_first_s[1:0];
      done_s  = 1'b0;
      state_s = (bus.delay0 == {CNT_W{1'b0}}) ? GEN : DELAY;
    end else if (bus.running) begin
      case (state_r)
        DELAY: begin
          // Leaving on the last delay cycle lets the first select land delay0+1 cycles after run.
          if (dcnt_r <= CNT_W'(1)) begin
            dcnt_s  = {CNT_W{1'b0}};
            state_s = GEN;
          end else begin
            dcnt_s  = dcnt_r - CNT_W'(1);
            state_s = DELAY;
          end
        end
        GEN: begin
          if (empty_s) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            out_s = {{(DATA_W-2){1'b0}}, slot_r};
            if (last_cyc_s) begin
              hcnt_s = {CNT_W{1'b0}};
              if (nxt_s[2]) begin
                slot_s = nxt_s[1:0];
              end else begin
                pass_s = pass_inc_s;
                slot_s = first_s[1:0];
                if (pass_inc_s == iter_r) begin
                  state_s = DONE;
                  done_s  = 1'b1;
                end else begin
                  state_s = GEN;
                end
              end
            end else begin
              hcnt_s = hcnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      dcnt_r  <= {CNT_W{1'b0}};
      hcnt_r  <= {CNT_W{1'b0}};
      pass_r  <= {CNT_W{1'b0}};
      slot_r  <= 2'd0;
      out_r   <= {DATA_W{1'b0}};
      done_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      dcnt_r  <= dcnt_s;
      hcnt_r  <= hcnt_s;
      pass_r  <= pass_s;
      slot_r  <= slot_s;
      out_r   <= out_s;
      done_r  <= done_s;
    end
  end

  // Shadow copy of the configuration, captured only on run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_r    <= {CNT_W{1'b0}};
      hold_r[0] <= {CNT_W{1'b0}};
      hold_r[1] <= {CNT_W{1'b0}};
      hold_r[2] <= {CNT_W{1'b0}};
      hold_r[3] <= {CNT_W{1'b0}};
    end else if (bus.run) begin
      iter_r    <= bus.iter;
      hold_r[0] <= bus.hold0;
      hold_r[1] <= bus.hold1;
      hold_r[2] <= bus.hold2;
      hold_r[3] <= bus.hold3;
    end
  end

  assign bus.out0 = out_r;
  assign bus.done = done_r;

endmodule
